// File: rtl/rotate_pattern_gen_if.sv
// Bundles the control, configuration, rotator and output-stream signals of rotate_pattern_gen.
// master: the generator's view (drives out_*, rot_data_in/rot_shift/rot_dir, busy, done).
// slave: the surrounding logic's view (drives start/abort/cfg_*, out_ready, rot_data_out).
interface rotate_pattern_gen_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [31:0]      cfg_seed;
  logic [4:0]       cfg_step;
  logic             cfg_dir;
  logic [CNT_W-1:0] cfg_beats;
  logic [31:0]      rot_data_in;
  logic [4:0]       rot_shift;
  logic             rot_dir;
  logic [31:0]      rot_data_out;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_last;
  logic             busy;
  logic             done;

  modport master (
    input  start, abort, cfg_seed, cfg_step, cfg_dir, cfg_beats, rot_data_out, out_ready,
    output rot_data_in, rot_shift, rot_dir, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    output start, abort, cfg_seed, cfg_step, cfg_dir, cfg_beats, rot_data_out, out_ready,
    input  rot_data_in, rot_shift, rot_dir, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/rotate_pattern_gen.sv
// Rotating pattern generator: emits cfg_beats words, each one the previous word rotated by an external rotator.
// Latency: first beat the cycle after an accepted start; one beat per cycle while out_ready is held high.
// Backpressure: out_data/out_last hold while out_valid && !out_ready. Ports: clk, rst, bus (master modport).
module rotate_pattern_gen #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rotate_pattern_gen_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      pattern;
  logic [4:0]       step;
  logic             dir;
  logic [CNT_W-1:0] remaining;
  logic             load;
  logic             xfer;

  // Next-state and datapath strobes. Abort is checked before the transfer so it
  // wins over the last-beat transition; the coinciding beat is simply dropped here.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.cfg_beats != '0) begin
            load      = 1'b1;
            state_nxt = RUN;
          end else begin
            // Zero-length request: no beats, just the completion pulse.
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (bus.out_ready && remaining != '0) begin
          xfer = 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern   <= '0;
      step      <= '0;
      dir       <= 1'b0;
      remaining <= '0;
    end else if (load) begin
      pattern   <= bus.cfg_seed;
      step      <= bus.cfg_step;
      dir       <= bus.cfg_dir;
      remaining <= bus.cfg_beats;
    end else if (xfer) begin
      pattern   <= bus.rot_data_out;
      remaining <= remaining - CNT_W'(1);
    end
  end

  // All outputs decode straight from registers, so an async reset clears them at once.
  assign bus.out_valid   = (state == RUN);
  assign bus.out_data    = pattern;
  assign bus.out_last    = (state == RUN) && (remaining == CNT_W'(1));
  assign bus.rot_data_in = pattern;
  assign bus.rot_shift   = step;
  assign bus.rot_dir     = dir;
  assign bus.busy        = (state == RUN) || (state == DONE);
  assign bus.done        = (state == DONE);

endmodule
